// File: rtl/apb_cmd_master_if.sv
// Bundle of the command/response handshake and the APB3 bus for apb_cmd_master.
// Handshakes: a beat transfers on the rising edge where valid and ready are both high; valid holds its payload until then.
interface apb_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready register command in, one APB transfer out, one response back.
// Optional wait-state timeout aborts an ACCESS phase that PREADY never ends.
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TO_CYCLES  = 256
) (
    input  logic             CK,
    input  logic             RST,
    apb_cmd_master_if.master bus,
    output logic [1:0]       dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam int CNT_W = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  cmd_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // cmd_ready comes up one cycle after reset, then stays high while idle
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        pwrite_q    <= bus.cmd_write;
                        paddr_q     <= bus.cmd_addr;
                        pwdata_q    <= bus.cmd_wdata;
                        psel_q      <= 1'b1;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                        rsp_err_q     <= bus.PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= S_RESP;
                    end else if (TO_CYCLES != 0 && cnt_q == CNT_LAST) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= S_RESP;
                    end else if (TO_CYCLES != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with TO_CYCLES=4; the APB slave is driven by hand per vector.
module tb_apb_cmd_master;
    logic       CK;
    logic       RST;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    int         acc_cycles;

    apb_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_cmd_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TO_CYCLES (4)
    ) dut (
        .CK         (CK),
        .RST        (RST),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Presents a command and returns in the SETUP cycle that follows acceptance.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        while (!bus.cmd_ready && n < 20) begin
            step();
            n++;
        end
        check("cmd_accept_wait", 32'(n < 20), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic rsp_handshake();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        check("idle_after_rsp", 32'(dbg_state), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        RST           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        step();
        step();
        RST = 1'b0;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_psel", 32'(bus.PSEL), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_paddr", bus.PADDR, 32'd0);
        step();
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Zero-wait write
        bus.PREADY = 1'b1;
        send_cmd(1'b1, 32'h40, 32'hA5A5_0001);
        check("wr_setup_psel", 32'(bus.PSEL), 32'd1);
        check("wr_setup_penable", 32'(bus.PENABLE), 32'd0);
        check("wr_setup_paddr", bus.PADDR, 32'h40);
        check("wr_setup_pwrite", 32'(bus.PWRITE), 32'd1);
        check("wr_setup_pwdata", bus.PWDATA, 32'hA5A5_0001);
        check("wr_setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        check("wr_access_psel", 32'(bus.PSEL), 32'd1);
        check("wr_access_penable", 32'(bus.PENABLE), 32'd1);
        step();
        check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("wr_rsp_psel", 32'(bus.PSEL), 32'd0);
        rsp_handshake();
        check("wr_next_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Read with three wait states
        bus.PREADY = 1'b0;
        send_cmd(1'b0, 32'h80, 32'hFFFF_FFFF);
        step();
        for (int i = 0; i < 3; i++) begin
            check("rd_wait_penable", 32'(bus.PENABLE), 32'd1);
            check("rd_wait_paddr", bus.PADDR, 32'h80);
            step();
        end
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h1234_5678;
        check("rd_last_penable", 32'(bus.PENABLE), 32'd1);
        check("rd_last_paddr", bus.PADDR, 32'h80);
        step();
        bus.PRDATA = 32'h0;
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rd_paddr_hold", bus.PADDR, 32'h80);
        rsp_handshake();

        // Slave error on a read
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hDEAD_BEEF;
        send_cmd(1'b0, 32'h84, 32'h0);
        step();
        step();
        bus.PSLVERR = 1'b0;
        check("err_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("err_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        check("err_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        rsp_handshake();

        // Timeout with PREADY stuck low
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hFFFF_FFFF;
        send_cmd(1'b0, 32'h88, 32'h0);
        step();
        acc_cycles = 0;
        while (bus.PENABLE && acc_cycles < 10) begin
            acc_cycles++;
            step();
        end
        check("to_access_cycles", 32'(acc_cycles), 32'd4);
        check("to_psel", 32'(bus.PSEL), 32'd0);
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("to_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
        check("to_rsp_rdata", bus.rsp_rdata, 32'd0);
        rsp_handshake();

        // PREADY on the last allowed cycle completes normally
        send_cmd(1'b0, 32'h8C, 32'h0);
        step();
        step();
        step();
        step();
        check("edge_still_access", 32'(bus.PENABLE), 32'd1);
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h55AA_55AA;
        step();
        check("edge_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("edge_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        check("edge_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("edge_rsp_rdata", bus.rsp_rdata, 32'h55AA_55AA);
        rsp_handshake();

        // Response backpressure with a second command waiting
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h3333_4444;
        send_cmd(1'b1, 32'h90, 32'h1111_2222);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h94;
        bus.cmd_wdata = 32'h0;
        step();
        check("bp_access_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'd0);
            check("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
        end
        check("bp_rsp_valid_final", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("bp_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        bus.cmd_valid = 1'b0;
        check("bp2_setup_psel", 32'(bus.PSEL), 32'd1);
        check("bp2_setup_paddr", bus.PADDR, 32'h94);
        check("bp2_setup_pwrite", 32'(bus.PWRITE), 32'd0);
        step();
        step();
        check("bp2_rsp_rdata", bus.rsp_rdata, 32'h3333_4444);
        rsp_handshake();

        // Reset during an ACCESS wait state
        bus.PREADY = 1'b0;
        send_cmd(1'b1, 32'hA0, 32'hCAFE_0001);
        step();
        step();
        check("rstacc_in_access", 32'(bus.PENABLE), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rstacc_psel", 32'(bus.PSEL), 32'd0);
        check("rstacc_penable", 32'(bus.PENABLE), 32'd0);
        check("rstacc_paddr", bus.PADDR, 32'd0);
        check("rstacc_pwdata", bus.PWDATA, 32'd0);
        check("rstacc_pwrite", 32'(bus.PWRITE), 32'd0);
        check("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstacc_state", 32'(dbg_state), 32'd0);
        step();
        check("rstacc_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h0F0F_0F0F;
        send_cmd(1'b0, 32'hA4, 32'h0);
        step();
        step();
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("post_rst_rsp_rdata", bus.rsp_rdata, 32'h0F0F_0F0F);
        rsp_handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB3 initiator that turns single-beat register commands (valid/ready) into APB transfers and returns a response (valid/ready).
- It is the requester end of the APB register interface that the DMA controller exposes as a completer. The team uses it to drive slave register ports from test sequencers and from internal bring-up and configuration logic.
- Handles one command at a time, enforces APB SETUP/ACCESS phasing, and supports a wait-state timeout.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write data, read data and PWDATA/PRDATA.
- TO_CYCLES, 256, maximum ACCESS-phase cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- CK  in  1  clock; everything sampled on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset is synchronous and active-high: RST is sampled on the CK rising edge.
  - Every output resets to 0 and the state machine goes to IDLE.
  - Reset mid-transfer drops PSEL/PENABLE at that edge and discards the command; no response is produced.
- State machine has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; all other control outputs are 0.
  - On cmd_valid&cmd_ready, cmd_write/cmd_addr/cmd_wdata are latched and the next state is SETUP.
- SETUP:
  - PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA come from the latched command.
  - Always goes to ACCESS next cycle.
  - The wait counter clears to 0.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA are unchanged from SETUP.
  - If PREADY=1: go to RESP.
    - rsp_rdata captures PRDATA for reads and is 0 for writes.
    - rsp_err captures PSLVERR; rsp_timeout=0.
  - Else if TO_CYCLES!=0 and the counter equals TO_CYCLES-1: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Else the counter increments and the block stays in ACCESS.
  - A PREADY=1 arriving on the final allowed cycle completes normally; no timeout is raised.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1; response fields are held stable.
  - On rsp_ready, go to IDLE. rsp_valid and the rsp_* fields clear to 0 in IDLE.
- cmd_ready is 0 outside IDLE. Commands presented then are not accepted and must be held by the source.
- PADDR/PWRITE/PWDATA hold their last values while PSEL=0. They do not reset to 0 between transfers, only on RST.
- Latency with a zero-wait slave:
  - Accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3.
  - With rsp_ready=1 at N+3, the block is in IDLE at N+4 and can accept a new command there.
- PSLVERR and PRDATA are sampled only when PSEL&PENABLE&PREADY are all high.
- The counter is $clog2(TO_CYCLES+1) bits wide and never wraps, because the block leaves ACCESS at the limit.

Test Plan:
- Write, zero-wait: cmd write addr 0x40 data 0xA5A5_0001 accepted at cycle 0, PREADY tied 1.
  - PSEL=1/PENABLE=0 at cycle 1, PENABLE=1 at cycle 2, rsp_valid=1 with rsp_err=0 and rsp_rdata=0 at cycle 3.
- Read, 3 wait states: PREADY low for 3 ACCESS cycles, then PRDATA=0x1234_5678.
  - ACCESS lasts 4 cycles and PADDR stays stable; rsp_rdata=0x1234_5678, rsp_err=0.
- Slave error: read completes with PSLVERR=1.
  - rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA value.
- Timeout (TO_CYCLES=4): PREADY held low.
  - Exactly 4 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Rerun with PREADY=1 on the 4th ACCESS cycle: normal completion, rsp_timeout=0.
- Response backpressure: rsp_ready low for 5 cycles with a second cmd_valid pending.
  - rsp_valid and data stay stable, cmd_ready=0 throughout.
  - The second command is accepted one cycle after the rsp handshake.
- Reset in ACCESS: assert RST for 1 cycle during a wait state.
  - PSEL/PENABLE=0 and all outputs 0 after that edge, no rsp_valid; the next command completes normally.
